// File: rtl/ps2_voice_allocator.sv
// ps2_voice_allocator: turns the decoded PS/2 byte stream into key make/break
// events and schedules them onto a fixed pool of tone-generator voices.
//   Clock        system clock, rising edge
//   btnCpuReset  asynchronous active-low reset
//   KCode        received scan-code byte (valid while isValid high)
//   isValid      one-cycle pulse marking a new byte on KCode
//   VoiceActive  bit i high while voice i holds a key
//   VoiceCodes   voice i key {extended, code} at [9i+8:9i]
//   NoteOn       one-cycle pulse, EventVoice newly allocated
//   NoteOff      one-cycle pulse, EventVoice released
//   EventVoice   voice index of the latest NoteOn/NoteOff
//   Dropped      one-cycle pulse, make code arrived with every voice busy
module ps2_voice_allocator #(
    parameter int unsigned VOICES  = 4,
    parameter int unsigned IDX_W   = 2,
    parameter int unsigned TIMEOUT = 100000,
    parameter int unsigned TO_W    = 17
) (
    input  logic                  Clock,
    input  logic                  btnCpuReset,
    input  logic [7:0]            KCode,
    input  logic                  isValid,
    output logic [VOICES-1:0]     VoiceActive,
    output logic [9*VOICES-1:0]   VoiceCodes,
    output logic                  NoteOn,
    output logic                  NoteOff,
    output logic [IDX_W-1:0]      EventVoice,
    output logic                  Dropped
);

    localparam int unsigned KEY_W = 9;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXT     = 2'd1;
    localparam logic [1:0] ST_BRK     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [TO_W-1:0]  to_cnt;
    logic [TO_W-1:0]  to_cnt_nxt;

    logic             ignored_c;
    logic             make_c;
    logic             brk_c;
    logic             ext_c;
    logic [KEY_W-1:0] key_c;

    logic             hit_c;
    logic [IDX_W-1:0] hit_idx_c;
    logic             free_c;
    logic [IDX_W-1:0] free_idx_c;

    // Bytes that never form a key: error, overrun, BAT-ok and ack responses.
    always_comb begin
        ignored_c = (KCode == 8'h00) || (KCode == 8'hFF) || (KCode == 8'hAA) ||
                    (KCode == 8'hFA) || (KCode == 8'hFE);
    end

    // Prefix FSM next state, key event decode and prefix timeout counter.
    always_comb begin
        state_nxt  = state;
        to_cnt_nxt = to_cnt;
        make_c     = 1'b0;
        brk_c      = 1'b0;
        ext_c      = 1'b0;
        if (isValid) begin
            to_cnt_nxt = '0;
            case (state)
                ST_IDLE: begin
                    if (KCode == 8'hE0) begin
                        state_nxt = ST_EXT;
                    end else if (KCode == 8'hF0) begin
                        state_nxt = ST_BRK;
                    end else begin
                        make_c = !ignored_c;
                    end
                end
                ST_EXT: begin
                    if (KCode == 8'hF0) begin
                        state_nxt = ST_EXT_BRK;
                    end else if (KCode != 8'hE0) begin
                        state_nxt = ST_IDLE;
                        make_c    = !ignored_c;
                        ext_c     = 1'b1;
                    end
                end
                ST_BRK: begin
                    state_nxt = ST_IDLE;
                    brk_c     = !ignored_c;
                end
                default: begin
                    state_nxt = ST_IDLE;
                    brk_c     = !ignored_c;
                    ext_c     = 1'b1;
                end
            endcase
        end else if (state != ST_IDLE) begin
            // Expire on the cycle the count would reach TIMEOUT.
            if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                state_nxt  = ST_IDLE;
                to_cnt_nxt = '0;
            end else begin
                to_cnt_nxt = to_cnt + TO_W'(1);
            end
        end
    end

    always_comb begin
        key_c = {ext_c, KCode};
    end

    // Descending scan so the lowest matching / lowest free index wins.
    always_comb begin
        hit_c      = 1'b0;
        hit_idx_c  = '0;
        free_c     = 1'b0;
        free_idx_c = '0;
        for (int i = VOICES - 1; i >= 0; i--) begin
            if (VoiceActive[i] && (VoiceCodes[KEY_W*i +: KEY_W] == key_c)) begin
                hit_c     = 1'b1;
                hit_idx_c = IDX_W'(i);
            end
            if (!VoiceActive[i]) begin
                free_c     = 1'b1;
                free_idx_c = IDX_W'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge Clock or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            state  <= ST_IDLE;
            to_cnt <= '0;
        end else begin
            state  <= state_nxt;
            to_cnt <= to_cnt_nxt;
        end
    end

    // Voice pool and event outputs.
    always_ff @(posedge Clock or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            VoiceActive <= '0;
            VoiceCodes  <= '0;
            NoteOn      <= 1'b0;
            NoteOff     <= 1'b0;
            Dropped     <= 1'b0;
            EventVoice  <= '0;
        end else begin
            NoteOn  <= 1'b0;
            NoteOff <= 1'b0;
            Dropped <= 1'b0;
            if (make_c && !hit_c) begin
                if (free_c) begin
                    for (int i = 0; i < VOICES; i++) begin
                        if (free_idx_c == IDX_W'(i)) begin
                            VoiceActive[i]                 <= 1'b1;
                            VoiceCodes[KEY_W*i +: KEY_W]   <= key_c;
                        end
                    end
                    NoteOn     <= 1'b1;
                    EventVoice <= free_idx_c;
                end else begin
                    Dropped <= 1'b1;
                end
            end else if (brk_c && hit_c) begin
                for (int i = 0; i < VOICES; i++) begin
                    if (hit_idx_c == IDX_W'(i)) begin
                        VoiceActive[i] <= 1'b0;
                    end
                end
                NoteOff    <= 1'b1;
                EventVoice <= hit_idx_c;
            end
        end
    end

endmodule

// File: tb/tb_ps2_voice_allocator.sv
// Bench for ps2_voice_allocator: directed vector table, hand-written timeout
// and reset sequences, and random byte traffic against a behavioural model.
module tb_ps2_voice_allocator;

    localparam int unsigned VOICES  = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned TIMEOUT = 20;
    localparam int unsigned TO_W    = 5;

    logic                Clock = 1'b0;
    logic                btnCpuReset;
    logic [7:0]          KCode;
    logic                isValid;
    logic [VOICES-1:0]   VoiceActive;
    logic [9*VOICES-1:0] VoiceCodes;
    logic                NoteOn;
    logic                NoteOff;
    logic [IDX_W-1:0]    EventVoice;
    logic                Dropped;

    ps2_voice_allocator #(
        .VOICES (VOICES),
        .IDX_W  (IDX_W),
        .TIMEOUT(TIMEOUT),
        .TO_W   (TO_W)
    ) dut (
        .Clock      (Clock),
        .btnCpuReset(btnCpuReset),
        .KCode      (KCode),
        .isValid    (isValid),
        .VoiceActive(VoiceActive),
        .VoiceCodes (VoiceCodes),
        .NoteOn     (NoteOn),
        .NoteOff    (NoteOff),
        .EventVoice (EventVoice),
        .Dropped    (Dropped)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] dut_vec();
        return 64'({NoteOn, NoteOff, Dropped, EventVoice, VoiceActive, VoiceCodes});
    endfunction

    // ---------------- behavioural model ----------------
    bit [VOICES-1:0] m_act;
    logic [8:0]      m_code [VOICES];
    bit              m_on, m_off, m_drop;
    logic [IDX_W-1:0] m_ev;
    bit              m_pend, m_ext, m_brk;
    int              m_last;
    int              cyc;

    task automatic model_reset();
        m_act = '0;
        for (int i = 0; i < VOICES; i++) m_code[i] = '0;
        m_on = 0; m_off = 0; m_drop = 0; m_ev = '0;
        m_pend = 0; m_ext = 0; m_brk = 0; m_last = 0; cyc = 0;
    endtask

    function automatic logic [63:0] model_vec();
        logic [9*VOICES-1:0] flat;
        for (int i = 0; i < VOICES; i++) flat[9*i +: 9] = m_code[i];
        return 64'({m_on, m_off, m_drop, m_ev, m_act, flat});
    endfunction

    // A prefix is still live if the next byte comes within TIMEOUT cycles.
    task automatic model(input bit v, input logic [7:0] k);
        bit pend, ex, br, ign, mk, bk, held;
        int idx;
        logic [8:0] key;
        m_on = 0; m_off = 0; m_drop = 0;
        if (!v) return;
        pend = m_pend && ((cyc - m_last) <= TIMEOUT);
        ex   = pend && m_ext;
        br   = pend && m_brk;
        ign  = (k == 8'h00) || (k == 8'hFF) || (k == 8'hAA) || (k == 8'hFA) || (k == 8'hFE);
        mk = 0; bk = 0;
        m_last = cyc;
        if (br) begin
            m_pend = 0; bk = !ign;
        end else if (k == 8'hF0) begin
            m_pend = 1; m_brk = 1; m_ext = ex;
        end else if (k == 8'hE0) begin
            m_pend = 1; m_brk = 0; m_ext = 1;
        end else begin
            m_pend = 0; mk = !ign;
        end
        key = {ex, k};
        if (mk) begin
            held = 0;
            for (int i = 0; i < VOICES; i++) if (m_act[i] && m_code[i] == key) held = 1;
            if (!held) begin
                idx = -1;
                for (int i = 0; i < VOICES; i++) if (!m_act[i] && idx < 0) idx = i;
                if (idx >= 0) begin
                    m_act[idx] = 1; m_code[idx] = key; m_on = 1; m_ev = IDX_W'(idx);
                end else begin
                    m_drop = 1;
                end
            end
        end else if (bk) begin
            for (int i = 0; i < VOICES; i++) begin
                if (m_act[i] && m_code[i] == key) begin
                    m_act[i] = 0; m_off = 1; m_ev = IDX_W'(i);
                end
            end
        end
    endtask

    // One clock: drive at a falling edge, check at the next falling edge.
    task automatic step(input bit v, input logic [7:0] k);
        logic [63:0] e;
        isValid = v;
        KCode   = k;
        model(v, k);
        e = model_vec();
        @(negedge Clock);
        chk("model", dut_vec(), e);
        cyc++;
    endtask

    task automatic do_reset();
        btnCpuReset = 1'b0;
        isValid = 1'b0;
        repeat (2) @(negedge Clock);
        btnCpuReset = 1'b1;
        model_reset();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit               v;
        logic [7:0]       k;
        bit               on, off, drop;
        logic [IDX_W-1:0] ev;
        logic [VOICES-1:0] act;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit v, input logic [7:0] k, input bit on, input bit off,
                       input bit drop, input logic [IDX_W-1:0] ev, input logic [VOICES-1:0] act);
        vec_t r;
        r.v = v; r.k = k; r.on = on; r.off = off; r.drop = drop; r.ev = ev; r.act = act;
        tbl.push_back(r);
    endtask

    logic [7:0] pool [10];

    initial begin
        btnCpuReset = 1'b0;
        isValid     = 1'b0;
        KCode       = 8'h00;
        model_reset();

        // reset state
        repeat (3) @(negedge Clock);
        chk("reset_state", dut_vec(), 64'd0);
        btnCpuReset = 1'b1;

        // make/break, typematic, allocation order, drop, reuse, extended keys
        add(1, 8'h1C, 1, 0, 0, 2'd0, 4'b0001);
        add(1, 8'hF0, 0, 0, 0, 2'd0, 4'b0001);
        add(1, 8'h1C, 0, 1, 0, 2'd0, 4'b0000);
        add(1, 8'h1C, 1, 0, 0, 2'd0, 4'b0001);
        add(1, 8'h1C, 0, 0, 0, 2'd0, 4'b0001);
        add(1, 8'h1C, 0, 0, 0, 2'd0, 4'b0001);
        add(1, 8'h1B, 1, 0, 0, 2'd1, 4'b0011);
        add(1, 8'h23, 1, 0, 0, 2'd2, 4'b0111);
        add(1, 8'h2B, 1, 0, 0, 2'd3, 4'b1111);
        add(1, 8'h34, 0, 0, 1, 2'd3, 4'b1111);
        add(1, 8'hF0, 0, 0, 0, 2'd3, 4'b1111);
        add(1, 8'h1B, 0, 1, 0, 2'd1, 4'b1101);
        add(1, 8'h34, 1, 0, 0, 2'd1, 4'b1111);
        add(1, 8'hF0, 0, 0, 0, 2'd1, 4'b1111);
        add(1, 8'h1C, 0, 1, 0, 2'd0, 4'b1110);
        add(1, 8'hF0, 0, 0, 0, 2'd0, 4'b1110);
        add(1, 8'h34, 0, 1, 0, 2'd1, 4'b1100);
        add(1, 8'hF0, 0, 0, 0, 2'd1, 4'b1100);
        add(1, 8'h23, 0, 1, 0, 2'd2, 4'b1000);
        add(1, 8'hF0, 0, 0, 0, 2'd2, 4'b1000);
        add(1, 8'h2B, 0, 1, 0, 2'd3, 4'b0000);
        add(1, 8'hE0, 0, 0, 0, 2'd3, 4'b0000);
        add(1, 8'h75, 1, 0, 0, 2'd0, 4'b0001);
        add(1, 8'hF0, 0, 0, 0, 2'd0, 4'b0001);
        add(1, 8'h75, 0, 0, 0, 2'd0, 4'b0001);
        add(1, 8'hE0, 0, 0, 0, 2'd0, 4'b0001);
        add(1, 8'hF0, 0, 0, 0, 2'd0, 4'b0001);
        add(1, 8'h75, 0, 1, 0, 2'd0, 4'b0000);
        add(1, 8'hAA, 0, 0, 0, 2'd0, 4'b0000);
        add(0, 8'h1C, 0, 0, 0, 2'd0, 4'b0000);

        @(negedge Clock);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].k);
            chk($sformatf("vec%0d", i), 64'({NoteOn, NoteOff, Dropped, EventVoice, VoiceActive}),
                64'({tbl[i].on, tbl[i].off, tbl[i].drop, tbl[i].ev, tbl[i].act}));
            if (i == 0) chk("vec0_code", 64'(VoiceCodes[8:0]), 64'h01C);
            if (i == 22) chk("ext_code", 64'(VoiceCodes[8:0]), 64'h175);
        end

        // F0 followed by TIMEOUT idle cycles: prefix expired, 1C is a make
        step(1, 8'hF0);
        repeat (TIMEOUT) step(0, 8'h1C);
        step(1, 8'h1C);
        chk("timeout_make", 64'({NoteOn, NoteOff, VoiceActive}), 64'({2'b10, 4'b0001}));

        // F0 with 1C on the last live cycle: still a break
        step(1, 8'hF0);
        repeat (TIMEOUT - 1) step(0, 8'h00);
        step(1, 8'h1C);
        chk("timeout_edge_break", 64'({NoteOn, NoteOff, VoiceActive}), 64'({2'b01, 4'b0000}));

        // Reset mid-prefix with three voices active
        step(1, 8'h1C);
        step(1, 8'h1B);
        step(1, 8'h23);
        step(1, 8'hE0);
        isValid = 1'b0;
        #3 btnCpuReset = 1'b0;
        #1 chk("async_reset", dut_vec(), 64'd0);
        @(negedge Clock);
        chk("reset_hold", dut_vec(), 64'd0);
        btnCpuReset = 1'b1;
        model_reset();
        step(1, 8'h1C);
        chk("post_reset_make", 64'({NoteOn, EventVoice, VoiceActive, VoiceCodes[8:0]}),
            64'({1'b1, 2'd0, 4'b0001, 9'h01C}));

        // Random traffic against the model
        pool = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h75, 8'hE0, 8'hF0, 8'hF0, 8'hAA};
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                repeat (TIMEOUT + $urandom_range(0, 2) - 1) step(0, 8'($urandom));
            end else if ($urandom_range(0, 2) == 0) begin
                step(0, 8'($urandom));
            end else begin
                step(1, pool[$urandom_range(0, 9)]);
            end
        end
        step(0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_voice_allocator.md
# ps2_voice_allocator

Consumes the decoded PS/2 byte stream (8-bit code plus one-cycle valid pulse from the keyboard receiver) and turns it into key-press and key-release events. Each event is scheduled onto a fixed pool of tone-generator voices. The block strips E0/F0 prefixes, filters typematic repeats, allocates the lowest free voice on a make code and releases the owning voice on a break code. It sits between the PS/2 receiver and the voice/tone generators of the piano datapath.

## Interface

Parameters:
- VOICES, 4, number of voice slots (2..8)
- IDX_W, 2, width of voice index, must satisfy 2^IDX_W >= VOICES
- TIMEOUT, 100000, Clock cycles a prefix state may wait for its next byte
- TO_W, 17, timeout counter width, 2^TO_W > TIMEOUT

Ports:
- Clock  in  1  system clock, all logic on rising edge
- btnCpuReset  in  1  reset, asynchronous, active-low
- KCode  in  8  received scan-code byte, stable while isValid high
- isValid  in  1  one-cycle pulse, KCode holds a new byte
- VoiceActive  out  VOICES  bit i high while voice i holds a key
- VoiceCodes  out  9*VOICES  voice i key at [9i+8:9i] = {extended, code}
- NoteOn  out  1  one-cycle pulse, voice EventVoice newly allocated
- NoteOff  out  1  one-cycle pulse, voice EventVoice released
- EventVoice  out  IDX_W  voice index for current NoteOn/NoteOff, holds last value otherwise
- Dropped  out  1  one-cycle pulse, new make code arrived with all voices busy

## Operation

- Prefix FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
- IDLE: byte 0xE0 -> EXT; 0xF0 -> BRK; 0x00, 0xFF, 0xAA, 0xFA, 0xFE -> ignored, stay IDLE; any other byte -> make {0,KCode}.
- EXT: 0xF0 -> EXT_BRK; 0xE0 -> stay EXT; ignored set -> IDLE, no event; other -> make {1,KCode}, IDLE.
- BRK: any byte outside the ignored set -> break {0,KCode}, IDLE; ignored byte -> IDLE, no event.
- EXT_BRK: same as BRK with key {1,KCode}.
- Make handling, evaluated against voice state before the update:
  - Key already held by an active voice (typematic repeat) -> no event.
  - Otherwise allocate the lowest-index inactive voice: set VoiceActive[i], load VoiceCodes slot i, pulse NoteOn, EventVoice=i.
  - No free voice -> pulse Dropped; no state change.
- Break handling: find the active voice whose code equals the key. Clear VoiceActive[i], pulse NoteOff, EventVoice=i. VoiceCodes slot i keeps its value. No match -> no event.
- At most one of NoteOn/NoteOff/Dropped fires per cycle.
- Timeout: a counter resets to 0 on every isValid and on entry to a non-IDLE state. It increments while the FSM is in EXT/BRK/EXT_BRK. Reaching TIMEOUT returns the FSM to IDLE with no event. If isValid arrives in the cycle the counter reaches TIMEOUT, isValid wins: the byte is processed in the current state.

## Timing

- Reset (async assert, sync release): state IDLE, counter 0, VoiceActive 0, VoiceCodes 0, NoteOn/NoteOff/Dropped 0, EventVoice 0.
- Reset asserted mid-prefix or with voices active clears everything immediately. No NoteOff is emitted for the cleared voices.
- Latency: isValid high in cycle n -> NoteOn/NoteOff/Dropped, EventVoice, VoiceActive and VoiceCodes updated, all registered, visible in cycle n+1.
- Back-to-back isValid pulses on consecutive cycles are supported. Each pulse is evaluated against state already updated by the previous one.
- isValid is ignored when low, regardless of KCode.

## Test plan

- Make 0x1C, then F0 1C -> NoteOn with EventVoice=0, VoiceCodes[8:0]=0x01C, VoiceActive=0001; then NoteOff with EventVoice=0, VoiceActive=0000.
- Make 0x1C three times (typematic) -> exactly one NoteOn, VoiceActive=0001.
- Makes 0x1C 0x1B 0x23 0x2B 0x34 -> voices 0..3 allocated in order, fifth byte pulses Dropped. Then F0 1B frees voice 1, and make 0x34 lands in voice 1.
- E0 75 then E0 F0 75 -> NoteOn with key 0x175; NoteOff for the same voice. Plain F0 75 sent while the key is held -> no NoteOff.
- F0 then TIMEOUT idle cycles, then 0x1C -> NoteOn, not a break. Same sequence with 0x1C arriving on exactly cycle TIMEOUT -> break handling, no NoteOn.
- Three voices active, assert btnCpuReset mid-E0 prefix -> all outputs 0 asynchronously. After release, 0x1C allocates voice 0.
